switch_recorder: RTL

Parametrised multi-channel switch-pattern recorder/player for the ThreeColorLight design, clocked by the divided clock `Div_CLK` (0.1 ms tick). It captures up to `CH` switch inputs as run-length entries {level vector, hold duration} into an internal `DEPTH`-entry buffer. On command it replays them on `play_out` with cycle-exact timing, either once or looping. It generalises the single-switch `Recording` block in channel count, buffer depth, duration width and playback mode, and sits between the switch inputs and the colour-light driver.

---
 rtl/switch_recorder_pkg.sv | 19 +
 rtl/rle_buffer.sv | 29 ++
 rtl/switch_recorder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/switch_recorder_pkg.sv
// Shared definitions for the switch-pattern recorder/player.
// Holds the FSM state encodings and helpers that derive the entry width
// and the buffer pointer width from the top-level parameters.
package switch_recorder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REC  = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;

  // One stored entry is {level vector, hold duration}.
  function automatic int ent_w(input int ch, input int dur_w);
    return ch + dur_w;
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rle_buffer.sv
// Run-length entry store: DEPTH x W register array with a single address
// shared by the synchronous write and the combinational read.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   addr_i   entry address (write and read)
//   wdata_i  entry to store
//   rdata_o  entry currently addressed
module rle_buffer #(
  parameter int DEPTH = 16,
  parameter int W     = 17,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/switch_recorder.sv
// Multi-channel switch-pattern recorder/player.
// Records synchronised switch levels as run-length entries {level, duration}
// and replays them with cycle-exact timing, once or looping.
// Ports:
//   Div_CLK      sole clock (rising edge)
//   rst_n        asynchronous active-low reset
//   sw_in        raw switch levels (asynchronous)
//   rec_start    pulse: clear buffer, start recording
//   rec_stop     pulse: end recording (flushes the open run)
//   play_start   pulse: start playback from entry 0
//   play_stop    pulse: abort playback
//   loop_en      wrap to entry 0 after the last entry
//   play_out     replayed levels (0 when not playing)
//   busy_rec     recording in progress
//   busy_play    playback in progress
//   full         buffer filled, recording stopped automatically
//   play_done    one-cycle pulse at end of non-looped playback
//   length       number of stored entries
module switch_recorder
  import switch_recorder_pkg::*;
#(
  parameter int CH    = 1,
  parameter int DEPTH = 16,
  parameter int DUR_W = 16
) (
  input  logic                     Div_CLK,
  input  logic                     rst_n,
  input  logic [CH-1:0]            sw_in,
  input  logic                     rec_start,
  input  logic                     rec_stop,
  input  logic                     play_start,
  input  logic                     play_stop,
  input  logic                     loop_en,
  output logic [CH-1:0]            play_out,
  output logic                     busy_rec,
  output logic                     busy_play,
  output logic                     full,
  output logic                     play_done,
  output logic [$clog2(DEPTH):0]   length
);

  localparam int AW = ptr_w(DEPTH);
  localparam int EW = ent_w(CH, DUR_W);
  localparam int LW = AW + 1;
  localparam logic [DUR_W-1:0] DUR_MAX = '1;

  logic [CH-1:0]    sync1_q, sync2_q;
  logic [1:0]       state_q, state_d;
  logic [LW-1:0]    len_q, len_d;
  logic             full_q, full_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CH-1:0]    out_q, out_d;
  logic             done_q, done_d;
  logic [CH-1:0]    cur_q, cur_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [DUR_W-1:0] remain_q, remain_d;

  logic             we;
  logic             ld;
  logic             rd_last;
  logic [AW-1:0]    addr;
  logic [EW-1:0]    rdata;

  rle_buffer #(
    .DEPTH (DEPTH),
    .W     (EW),
    .AW    (AW)
  ) u_buf (
    .clk_i   (Div_CLK),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i ({cur_q, dur_q}),
    .rdata_o (rdata)
  );

  // The write pointer is the entry count itself; in REC it never reaches DEPTH.
  assign rd_last = ({1'b0, rd_ptr_q} == (len_q - LW'(1)));

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    full_d   = full_q;
    rd_ptr_d = rd_ptr_q;
    out_d    = out_q;
    done_d   = 1'b0;
    cur_d    = cur_q;
    dur_d    = dur_q;
    remain_d = remain_q;
    we       = 1'b0;
    ld       = 1'b0;
    addr     = len_q[AW-1:0];

    case (state_q)
      ST_IDLE: begin
        if (rec_start) begin
          state_d = ST_REC;
          len_d   = '0;
          full_d  = 1'b0;
          cur_d   = sync2_q;
          dur_d   = DUR_W'(1);
        end else if (play_start && (len_q != '0)) begin
          state_d  = ST_PLAY;
          addr     = '0;
          rd_ptr_d = '0;
          ld       = 1'b1;
        end
      end

      ST_REC: begin
        if (rec_stop) begin
          we      = 1'b1;
          len_d   = len_q + LW'(1);
          state_d = ST_IDLE;
          if (len_q == LW'(DEPTH - 1)) full_d = 1'b1;
        end else if ((sync2_q == cur_q) && (dur_q != DUR_MAX)) begin
          dur_d = dur_q + DUR_W'(1);
        end else begin
          // Level change or saturated run: close the run and open a new one.
          we    = 1'b1;
          len_d = len_q + LW'(1);
          cur_d = sync2_q;
          dur_d = DUR_W'(1);
          if (len_q == LW'(DEPTH - 1)) begin
            full_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_PLAY: begin
        if (rec_start) begin
          state_d = ST_REC;
          len_d   = '0;
          full_d  = 1'b0;
          cur_d   = sync2_q;
          dur_d   = DUR_W'(1);
          out_d   = '0;
        end else if (play_stop) begin
          state_d = ST_IDLE;
          out_d   = '0;
        end else if (remain_q == DUR_W'(1)) begin
          // Last cycle of this entry: fetch the next one so there is no gap.
          if (!rd_last) begin
            addr     = rd_ptr_q + AW'(1);
            rd_ptr_d = rd_ptr_q + AW'(1);
            ld       = 1'b1;
          end else if (loop_en) begin
            addr     = '0;
            rd_ptr_d = '0;
            ld       = 1'b1;
          end else begin
            state_d = ST_IDLE;
            out_d   = '0;
            done_d  = 1'b1;
          end
        end else begin
          remain_d = remain_q - DUR_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (ld) begin
      out_d    = rdata[EW-1 -: CH];
      remain_d = rdata[DUR_W-1:0];
    end
  end

  always_ff @(posedge Div_CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      state_q  <= ST_IDLE;
      len_q    <= '0;
      full_q   <= 1'b0;
      rd_ptr_q <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      sync1_q  <= sw_in;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      len_q    <= len_d;
      full_q   <= full_d;
      rd_ptr_q <= rd_ptr_d;
      out_q    <= out_d;
      done_q   <= done_d;
    end
  end

  // Run and countdown registers are only meaningful inside REC/PLAY.
  always_ff @(posedge Div_CLK) begin
    cur_q    <= cur_d;
    dur_q    <= dur_d;
    remain_q <= remain_d;
  end

  assign play_out  = out_q;
  assign busy_rec  = (state_q == ST_REC);
  assign busy_play = (state_q == ST_PLAY);
  assign full      = full_q;
  assign play_done = done_q;
  assign length    = len_q;

endmodule
